// File: rtl/int_to_single.sv
// int_to_single
//   Converts a 32-bit signed two's-complement integer into an IEEE-754
//   single-precision value. Rounding is to nearest, with ties going to even.
//   The block is a multi-cycle FSM. Its normaliser shifts one bit per cycle.
//
// Ports
//   clk           sole clock, rising edge
//   rst           synchronous, active-high reset
//   input_a       signed integer operand
//   input_a_stb   upstream strobe: input_a is valid
//   input_a_ack   high while the block can accept an operand
//   output_z      IEEE-754 single result, held stable while output_z_stb is high
//   output_z_stb  high while output_z is valid
//   output_z_ack  downstream acknowledge; transfer on edge with stb & ack high
module int_to_single (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    typedef enum logic [2:0] {
        GET_A,
        CONVERT,
        NORMALISE,
        ROUND,
        PACK,
        PUT_Z
    } state_t;

    state_t             state;
    logic signed [31:0] a;
    logic        [31:0] m;
    logic        [7:0]  e;
    logic               sign;
    logic        [22:0] frac;

    logic        [31:0] a_mag;
    logic        [23:0] rnd;

    // Round-to-nearest-even of a normalised 32-bit magnitude down to 24 bits.
    // The result is {exponent_carry, fraction[22:0]}. The hidden bit is always
    // one after normalisation, so it is not returned.
    function automatic logic [23:0] round_rne(input logic [31:0] mv);
        logic        inc;
        logic [24:0] sum;
        inc = mv[7] & (mv[6] | (|mv[5:0]) | mv[8]);
        sum = {1'b0, mv[31:8]} + {24'd0, inc};
        // A carry out of 24 bits means the mantissa was all ones. The value
        // becomes 1.0 x 2^(e+1), so the fraction is zero.
        if (sum[24]) begin
            round_rne = {1'b1, 23'd0};
        end else begin
            round_rne = {1'b0, sum[22:0]};
        end
    endfunction

    // Magnitude as unsigned. The value -2^31 maps to 0x80000000 without overflow.
    always_comb begin
        a_mag = $unsigned(a);
        if (a[31]) begin
            a_mag = 32'd0 - $unsigned(a);
        end
    end

    always_comb begin
        rnd = round_rne(m);
    end

    // Control registers are reset. The datapath registers (a, m, e, sign, frac)
    // are always written before they are used, so they carry no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= GET_A;
            input_a_ack  <= 1'b1;
            output_z_stb <= 1'b0;
            output_z     <= 32'h0000_0000;
        end else begin
            case (state)
                GET_A: begin
                    input_a_ack <= 1'b1;
                    if (input_a_stb && input_a_ack) begin
                        a           <= input_a;
                        input_a_ack <= 1'b0;
                        state       <= CONVERT;
                    end
                end

                CONVERT: begin
                    if (a == 32'sd0) begin
                        output_z     <= 32'h0000_0000;
                        output_z_stb <= 1'b1;
                        state        <= PUT_Z;
                    end else begin
                        sign  <= a[31];
                        m     <= a_mag;
                        e     <= 8'd158;
                        state <= NORMALISE;
                    end
                end

                // Shift one bit per cycle until the leading one reaches bit 31.
                // The cycle that finds bit 31 set performs no shift.
                NORMALISE: begin
                    if (!m[31]) begin
                        m <= m << 1;
                        e <= e - 8'd1;
                    end else begin
                        state <= ROUND;
                    end
                end

                ROUND: begin
                    frac  <= rnd[22:0];
                    e     <= e + {7'd0, rnd[23]};
                    state <= PACK;
                end

                PACK: begin
                    output_z     <= {sign, e, frac};
                    output_z_stb <= 1'b1;
                    state        <= PUT_Z;
                end

                PUT_Z: begin
                    if (output_z_ack) begin
                        output_z_stb <= 1'b0;
                        input_a_ack  <= 1'b1;
                        state        <= GET_A;
                    end
                end

                default: begin
                    state        <= GET_A;
                    input_a_ack  <= 1'b1;
                    output_z_stb <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_to_single.sv
// Testbench for int_to_single.
//   The driver issues operands and pushes the expected result and the expected
//   cycle of output strobe rise into a queue. A separate monitor pops an entry
//   on every output transfer and compares it. Random operands are checked
//   against an arithmetic reference model of integer-to-float conversion.
module tb_int_to_single;

    logic        clk;
    logic        rst;
    logic [31:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;

    int_to_single dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] z;
        int          rise;
    } exp_t;
    exp_t exp_q[$];

    // 0: ack always high, 1: random ack, 2: hold ack low 10 cycles after stb rises
    int ack_mode = 0;
    int bp_cnt   = 0;

    // Reference model. It finds the top set bit of |a|, keeps 24 significant
    // bits, and rounds the discarded remainder to nearest, ties to even.
    function automatic void model(input logic [31:0] a, output logic [31:0] z, output int k);
        longint sa, mag, q, rem, half;
        int     p, sh;
        logic   s;
        sa = longint'($signed(a));
        if (sa == 0) begin
            z = 32'h0;
            k = 1;
            return;
        end
        s   = (sa < 0);
        mag = s ? -sa : sa;
        p   = 0;
        for (int i = 0; i < 32; i++) if (mag >= (64'sd1 <<< i)) p = i;
        k = 4 + (31 - p);
        if (p <= 23) begin
            q = mag <<< (23 - p);
        end else begin
            sh   = p - 23;
            q    = mag >>> sh;
            rem  = mag - (q <<< sh);
            half = 64'sd1 <<< (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (64'sd1 <<< 24)) begin
                q = q >>> 1;
                p = p + 1;
            end
        end
        z = {s, 8'(p + 127), q[22:0]};
    endfunction

    // Downstream acknowledge, changed just after each rising edge.
    initial begin
        output_z_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ack_mode)
                0: output_z_ack = 1'b1;
                1: output_z_ack = 1'($urandom_range(0, 1));
                default: begin
                    if (!output_z_stb) begin
                        bp_cnt       = 0;
                        output_z_ack = 1'b0;
                    end else if (bp_cnt < 10) begin
                        bp_cnt       = bp_cnt + 1;
                        output_z_ack = 1'b0;
                    end else begin
                        output_z_ack = 1'b1;
                    end
                end
            endcase
        end
    end

    // Monitor: compares on each transfer and checks stability under backpressure.
    logic        prev_stb  = 1'b0;
    logic        prev_held = 1'b0;
    logic [31:0] prev_z    = 32'h0;
    int          rise_cyc  = 0;

    always @(negedge clk) begin
        exp_t x;
        if (rst) begin
            prev_stb  = 1'b0;
            prev_held = 1'b0;
        end else begin
            if (output_z_stb && !prev_stb) rise_cyc = cyc;
            if (prev_held) begin
                checks++;
                if (output_z !== prev_z || output_z_stb !== 1'b1 || input_a_ack !== 1'b0) begin
                    errors++;
                    $display("FAIL hold: z=%h stb=%b ack=%b required z=%h stb=1 ack=0",
                             output_z, output_z_stb, input_a_ack, prev_z);
                end
            end
            if (output_z_stb && output_z_ack) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: z=%h with no pending operand", output_z);
                end else begin
                    x = exp_q.pop_front();
                    if (output_z !== x.z) begin
                        errors++;
                        $display("FAIL result a=%h: z=%h required %h", x.a, output_z, x.z);
                    end
                    checks++;
                    if (rise_cyc != x.rise) begin
                        errors++;
                        $display("FAIL latency a=%h: stb rose at cycle %0d required %0d",
                                 x.a, rise_cyc, x.rise);
                    end
                end
            end
            prev_held = output_z_stb && !output_z_ack;
            prev_stb  = output_z_stb;
            prev_z    = output_z;
        end
    end

    // Issue one operand. A table value of z/k is used when given, else the model.
    task automatic issue(input logic [31:0] a, input logic use_tab,
                         input logic [31:0] tz, input int tk);
        logic [31:0] mz;
        int          mk;
        int          n;
        exp_t        x;
        n = 0;
        @(negedge clk);
        while (!input_a_ack && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!input_a_ack) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: input_a_ack=%b required 1", input_a_ack);
            return;
        end
        input_a     = a;
        input_a_stb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        input_a_stb = 1'b0;
        input_a     = $urandom;
        model(a, mz, mk);
        x.a    = a;
        x.z    = use_tab ? tz : mz;
        x.rise = cyc + (use_tab ? tk : mk);
        exp_q.push_back(x);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || output_z_stb) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results pending required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    logic [31:0] tab_a [9] = '{32'd1, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'h7FFF_FFFF,
                               32'd16777217, 32'd16777219, 32'd16777221, 32'd3};
    logic [31:0] tab_z [9] = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 32'hCF00_0000,
                               32'h4F00_0000, 32'h4B80_0000, 32'h4B80_0002, 32'h4B80_0002,
                               32'h4040_0000};
    int          tab_k [9] = '{35, 35, 1, 4, 5, 11, 11, 11, 34};

    initial begin
        logic [31:0] v;
        rst         = 1'b1;
        input_a     = 32'h0;
        input_a_stb = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (output_z !== 32'h0 || output_z_stb !== 1'b0 || input_a_ack !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: z=%h stb=%b ack=%b required z=00000000 stb=0 ack=1",
                     output_z, output_z_stb, input_a_ack);
        end
        rst = 1'b0;

        // Directed values with ack held high.
        ack_mode = 0;
        for (int i = 0; i < 9; i++) issue(tab_a[i], 1'b1, tab_z[i], tab_k[i]);
        drain();

        // Backpressure: ack held low for 10 cycles, strobe pulses must be ignored.
        ack_mode = 2;
        issue(32'd16777219, 1'b1, 32'h4B80_0002, 11);
        while (!output_z_stb) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (output_z_stb && !output_z_ack) begin
                input_a     = $urandom;
                input_a_stb = 1'b1;
            end
            @(negedge clk);
            input_a_stb = 1'b0;
        end
        drain();
        ack_mode = 0;

        // Reset during NORMALISE of a=1: the partial result is abandoned.
        issue(32'd1, 1'b1, 32'h3F80_0000, 35);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        checks++;
        if (output_z_stb !== 1'b0 || input_a_ack !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: stb=%b ack=%b required stb=0 ack=1",
                     output_z_stb, input_a_ack);
        end
        issue(32'd3, 1'b1, 32'h4040_0000, 34);
        drain();

        // Random stream with varying magnitude, sign and downstream ack.
        for (int i = 0; i < 1000; i++) begin
            ack_mode = (i < 500) ? 0 : 1;
            v = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) v = 32'd0 - v;
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            issue(v, 1'b0, 32'h0, 0);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
